// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared widths, register count and controller state encoding
//               for the register-file access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int REG_DATA_W  = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int DBG_WAIT_W  = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_fwd.sv
`default_nettype none
// ============================================================================
// Module      : regfile_fwd
// Description : One read port's write-forward capture and response mux. At a
//               read grant it remembers whether the same-cycle write hits the
//               address being read, because the BRAM returns the old value.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_fwd
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rd_en,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_reg,
    input  logic [REG_DATA_W-1:0] i_wr_data,
    input  logic [REG_DATA_W-1:0] i_rf_data,
    output logic [REG_DATA_W-1:0] o_rsp_data
);

    logic                  r_fwd;
    logic [REG_DATA_W-1:0] r_fwd_data;

    // Capture the forward decision and the write data alongside each read grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
        end else if (i_rd_en) begin
            r_fwd      <= i_wr_en && (i_wr_reg == i_rd_addr) && (i_rd_addr != '0);
            r_fwd_data <= i_wr_data;
        end
    end

    assign o_rsp_data = r_fwd ? r_fwd_data : i_rf_data;

endmodule
`default_nettype wire

// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_ctrl
// Description : Access controller in front of the BRAM register file. Clears
//               x1..x(N-1) after reset, arbitrates CPU and debug access to the
//               read/write ports (debug read gains priority after a bounded
//               wait) and forwards same-cycle write data to reads.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int DBG_MAX_WAIT = 8,
    parameter int NUM_REGS     = RF_NUM_REGS
)(
    input  logic                  clk,
    input  logic                  reset,
    output logic                  busy,
    // CPU pipeline side
    input  logic                  cpu_rd_req,
    input  logic [REG_ADDR_W-1:0] cpu_rs1,
    input  logic [REG_ADDR_W-1:0] cpu_rs2,
    output logic                  cpu_rd_gnt,
    output logic                  cpu_rd_valid,
    output logic [REG_DATA_W-1:0] cpu_rd_data_1,
    output logic [REG_DATA_W-1:0] cpu_rd_data_2,
    input  logic                  cpu_wr_en,
    input  logic [REG_ADDR_W-1:0] cpu_wr_reg,
    input  logic [REG_DATA_W-1:0] cpu_wr_data,
    // Debug side
    input  logic                  dbg_rd_req,
    input  logic                  dbg_wr_req,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    input  logic [REG_DATA_W-1:0] dbg_wr_data,
    output logic                  dbg_rd_gnt,
    output logic                  dbg_wr_ack,
    output logic                  dbg_rd_valid,
    output logic [REG_DATA_W-1:0] dbg_rd_data,
    // Register file side
    output logic                  rf_rd_1_en,
    output logic                  rf_rd_2_en,
    output logic [REG_ADDR_W-1:0] rf_read_reg_1,
    output logic [REG_ADDR_W-1:0] rf_read_reg_2,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_reg,
    output logic [REG_DATA_W-1:0] rf_write_data,
    input  logic [REG_DATA_W-1:0] rf_data_out_1,
    input  logic [REG_DATA_W-1:0] rf_data_out_2
);

    localparam logic [REG_ADDR_W-1:0] C_LAST_REG = REG_ADDR_W'(NUM_REGS - 1);
    localparam logic [DBG_WAIT_W-1:0] C_WAIT_MAX = DBG_WAIT_W'(DBG_MAX_WAIT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [REG_ADDR_W-1:0] r_clr_cnt;
    logic [REG_ADDR_W-1:0] w_clr_cnt_nxt;
    logic [DBG_WAIT_W-1:0] r_dbg_wait;
    logic [DBG_WAIT_W-1:0] w_dbg_wait_nxt;
    logic                  r_cpu_valid;
    logic                  r_dbg_valid;

    logic                  w_rd_en   [2];
    logic [REG_ADDR_W-1:0] w_rd_addr [2];
    logic [REG_DATA_W-1:0] w_rf_out  [2];
    logic [REG_DATA_W-1:0] w_rsp     [2];

    // State, sweep pointer, debug wait counter and response valids
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= REG_ADDR_W'(1);
            r_dbg_wait  <= '0;
            r_cpu_valid <= 1'b0;
            r_dbg_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_dbg_wait  <= w_dbg_wait_nxt;
            r_cpu_valid <= cpu_rd_gnt;
            r_dbg_valid <= dbg_rd_gnt;
        end
    end

    // Next state, clear sweep, write/read arbitration and wait-counter update
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_cnt_nxt  = r_clr_cnt;
        w_dbg_wait_nxt = r_dbg_wait;
        busy           = 1'b1;
        cpu_rd_gnt     = 1'b0;
        dbg_rd_gnt     = 1'b0;
        dbg_wr_ack     = 1'b0;
        rf_write_en    = 1'b0;
        rf_write_reg   = cpu_wr_reg;
        rf_write_data  = cpu_wr_data;
        rf_rd_1_en     = 1'b0;
        rf_rd_2_en     = 1'b0;
        rf_read_reg_1  = cpu_rs1;
        rf_read_reg_2  = cpu_rs2;

        if (!reset) begin
            case (r_state)
                ST_CLEAR: begin
                    rf_write_en   = 1'b1;
                    rf_write_reg  = r_clr_cnt;
                    rf_write_data = '0;
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                    if (r_clr_cnt == C_LAST_REG) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    busy = 1'b0;
                    // CPU write always wins the write port; x0 is never written
                    if (cpu_wr_en) begin
                        rf_write_en = (cpu_wr_reg != '0);
                    end else if (dbg_wr_req) begin
                        dbg_wr_ack    = 1'b1;
                        rf_write_reg  = dbg_addr;
                        rf_write_data = dbg_wr_data;
                        rf_write_en   = (dbg_addr != '0);
                    end
                    // A pending debug write is served before the debug read
                    if (dbg_rd_req && !dbg_wr_req &&
                        (!cpu_rd_req || (r_dbg_wait == C_WAIT_MAX))) begin
                        dbg_rd_gnt    = 1'b1;
                        rf_rd_1_en    = 1'b1;
                        rf_read_reg_1 = dbg_addr;
                    end else if (cpu_rd_req) begin
                        cpu_rd_gnt = 1'b1;
                        rf_rd_1_en = 1'b1;
                        rf_rd_2_en = 1'b1;
                    end
                end
                default: w_state_nxt = ST_CLEAR;
            endcase

            if (dbg_rd_gnt) begin
                w_dbg_wait_nxt = '0;
            end else if (dbg_rd_req && (r_dbg_wait < C_WAIT_MAX)) begin
                w_dbg_wait_nxt = r_dbg_wait + 1'b1;
            end
        end
    end

    // A response already in flight is dropped as soon as reset is seen
    assign cpu_rd_valid = r_cpu_valid && !reset;
    assign dbg_rd_valid = r_dbg_valid && !reset;

    assign w_rd_en[0]   = rf_rd_1_en;
    assign w_rd_en[1]   = rf_rd_2_en;
    assign w_rd_addr[0] = rf_read_reg_1;
    assign w_rd_addr[1] = rf_read_reg_2;
    assign w_rf_out[0]  = rf_data_out_1;
    assign w_rf_out[1]  = rf_data_out_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            regfile_fwd u_fwd (
                .clk        (clk),
                .reset      (reset),
                .i_rd_en    (w_rd_en[gi]),
                .i_rd_addr  (w_rd_addr[gi]),
                .i_wr_en    (rf_write_en),
                .i_wr_reg   (rf_write_reg),
                .i_wr_data  (rf_write_data),
                .i_rf_data  (w_rf_out[gi]),
                .o_rsp_data (w_rsp[gi])
            );
        end
    endgenerate

    // Debug reads always use port 1, so it shares that response path
    assign cpu_rd_data_1 = w_rsp[0];
    assign cpu_rd_data_2 = w_rsp[1];
    assign dbg_rd_data   = w_rsp[0];

endmodule
`default_nettype wire

// File: tb/tb_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_ctrl
// Description : Directed self-checking bench for regfile_ctrl with a BRAM
//               register-file model (stale read on same-cycle write) and a
//               response scoreboard keyed by the expected valid cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_ctrl;

    localparam int C_DBG_MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        cpu_rd_req;
    logic [4:0]  cpu_rs1, cpu_rs2;
    logic        cpu_rd_gnt, cpu_rd_valid;
    logic [31:0] cpu_rd_data_1, cpu_rd_data_2;
    logic        cpu_wr_en;
    logic [4:0]  cpu_wr_reg;
    logic [31:0] cpu_wr_data;
    logic        dbg_rd_req, dbg_wr_req;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wr_data;
    logic        dbg_rd_gnt, dbg_wr_ack, dbg_rd_valid;
    logic [31:0] dbg_rd_data;
    logic        rf_rd_1_en, rf_rd_2_en;
    logic [4:0]  rf_read_reg_1, rf_read_reg_2;
    logic        rf_write_en;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [31:0] rf_data_out_1, rf_data_out_2;

    typedef struct {
        bit          is_dbg;
        logic [31:0] d1;
        logic [31:0] d2;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [32];
    logic [31:0] mem [32] = '{default: 32'hBAD0_BAD0};
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    regfile_ctrl #(.DBG_MAX_WAIT(C_DBG_MAX), .NUM_REGS(32)) dut (
        .clk(clk), .reset(reset), .busy(busy),
        .cpu_rd_req(cpu_rd_req), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
        .cpu_rd_gnt(cpu_rd_gnt), .cpu_rd_valid(cpu_rd_valid),
        .cpu_rd_data_1(cpu_rd_data_1), .cpu_rd_data_2(cpu_rd_data_2),
        .cpu_wr_en(cpu_wr_en), .cpu_wr_reg(cpu_wr_reg), .cpu_wr_data(cpu_wr_data),
        .dbg_rd_req(dbg_rd_req), .dbg_wr_req(dbg_wr_req), .dbg_addr(dbg_addr),
        .dbg_wr_data(dbg_wr_data), .dbg_rd_gnt(dbg_rd_gnt), .dbg_wr_ack(dbg_wr_ack),
        .dbg_rd_valid(dbg_rd_valid), .dbg_rd_data(dbg_rd_data),
        .rf_rd_1_en(rf_rd_1_en), .rf_rd_2_en(rf_rd_2_en),
        .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data),
        .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2)
    );

    // BRAM register file: registered reads return pre-write contents, x0 reads 0
    always @(posedge clk) begin
        if (rf_rd_1_en) rf_data_out_1 <= (rf_read_reg_1 == 5'd0) ? 32'd0 : mem[rf_read_reg_1];
        if (rf_rd_2_en) rf_data_out_2 <= (rf_read_reg_2 == 5'd0) ? 32'd0 : mem[rf_read_reg_2];
        if (rf_write_en) mem[rf_write_reg] <= rf_write_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Settle after driving, then check this cycle's response against the scoreboard
    task automatic settle();
        exp_t e;
        #1;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk1("rsp_cpu_valid", cpu_rd_valid, !e.is_dbg);
            chk1("rsp_dbg_valid", dbg_rd_valid, e.is_dbg);
            if (e.is_dbg) begin
                chk32("rsp_dbg_data", dbg_rd_data, e.d1);
            end else begin
                chk32("rsp_cpu_data_1", cpu_rd_data_1, e.d1);
                chk32("rsp_cpu_data_2", cpu_rd_data_2, e.d2);
            end
        end else begin
            chk1("idle_cpu_valid", cpu_rd_valid, 1'b0);
            chk1("idle_dbg_valid", dbg_rd_valid, 1'b0);
        end
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic push_cpu();
        sb.push_back('{is_dbg: 1'b0, d1: model[cpu_rs1], d2: model[cpu_rs2], cyc: cyc + 1});
    endtask

    task automatic push_dbg();
        sb.push_back('{is_dbg: 1'b1, d1: model[dbg_addr], d2: 32'd0, cyc: cyc + 1});
    endtask

    task automatic idle_inputs();
        cpu_rd_req = 1'b0;
        cpu_wr_en  = 1'b0;
        dbg_rd_req = 1'b0;
        dbg_wr_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            reset = 1'b1;
            settle();
            chk1("rst_busy", busy, 1'b1);
            chk1("rst_write_en", rf_write_en, 1'b0);
            chk1("rst_rd_1_en", rf_rd_1_en, 1'b0);
            chk1("rst_cpu_gnt", cpu_rd_gnt, 1'b0);
            chk1("rst_dbg_gnt", dbg_rd_gnt, 1'b0);
            chk1("rst_dbg_ack", dbg_wr_ack, 1'b0);
        end
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic sweep(input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            reset = 1'b0;
            settle();
            chk1("sweep_write_en", rf_write_en, 1'b1);
            chk32("sweep_write_reg", 32'(rf_write_reg), 32'(k));
            chk32("sweep_write_data", rf_write_data, 32'd0);
            chk1("sweep_busy", busy, 1'b1);
            chk1("sweep_cpu_gnt", cpu_rd_gnt, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        idle_inputs();
        cpu_rs1     = 5'd1;
        cpu_rs2     = 5'd31;
        cpu_wr_reg  = 5'd0;
        cpu_wr_data = 32'd0;
        dbg_addr    = 5'd0;
        dbg_wr_data = 32'd0;

        // Reset with a CPU read held pending across the whole sweep
        cpu_rd_req = 1'b1;
        do_reset(2);
        sweep(31);
        tick();
        settle();
        chk1("post_sweep_busy", busy, 1'b0);
        chk1("post_sweep_cpu_gnt", cpu_rd_gnt, 1'b1);
        chk32("post_sweep_rd_reg_1", 32'(rf_read_reg_1), 32'd1);
        push_cpu();

        // Basic write then read
        tick();
        cpu_rd_req = 1'b0; cpu_wr_en = 1'b1; cpu_wr_reg = 5'd5; cpu_wr_data = 32'hDEAD_BEEF;
        model_write(cpu_wr_reg, cpu_wr_data);
        settle();
        chk1("wr5_en", rf_write_en, 1'b1);
        chk32("wr5_reg", 32'(rf_write_reg), 32'd5);
        chk32("wr5_data", rf_write_data, 32'hDEAD_BEEF);
        chk1("wr5_no_gnt", cpu_rd_gnt, 1'b0);

        tick();
        cpu_wr_en = 1'b0; cpu_rd_req = 1'b1; cpu_rs1 = 5'd5; cpu_rs2 = 5'd0;
        settle();
        chk1("rd5_gnt", cpu_rd_gnt, 1'b1);
        chk1("rd5_rd_2_en", rf_rd_2_en, 1'b1);
        push_cpu();

        // Same-cycle write and read: forwarded, back-to-back grants
        tick();
        cpu_wr_en = 1'b1; cpu_wr_reg = 5'd7; cpu_wr_data = 32'h1234_5678;
        cpu_rs1 = 5'd7; cpu_rs2 = 5'd7;
        model_write(cpu_wr_reg, cpu_wr_data);
        settle();
        chk1("fwd7_gnt", cpu_rd_gnt, 1'b1);
        push_cpu();

        tick();
        cpu_wr_reg = 5'd0; cpu_wr_data = 32'hFFFF_FFFF; cpu_rs1 = 5'd0; cpu_rs2 = 5'd0;
        model_write(cpu_wr_reg, cpu_wr_data);
        settle();
        chk1("wr_x0_blocked", rf_write_en, 1'b0);
        chk1("fwd0_gnt", cpu_rd_gnt, 1'b1);
        push_cpu();

        tick();
        idle_inputs();
        settle();

        // Debug starvation, twice to show the wait counter restarts from 0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i <= C_DBG_MAX; i++) begin
                tick();
                cpu_rd_req = 1'b1; cpu_rs1 = 5'd5; cpu_rs2 = 5'd7;
                dbg_rd_req = 1'b1; dbg_addr = 5'd7;
                settle();
                if (i < C_DBG_MAX) begin
                    chk1("starve_cpu_gnt", cpu_rd_gnt, 1'b1);
                    chk1("starve_dbg_gnt", dbg_rd_gnt, 1'b0);
                    push_cpu();
                end else begin
                    chk1("prio_dbg_gnt", dbg_rd_gnt, 1'b1);
                    chk1("prio_cpu_gnt", cpu_rd_gnt, 1'b0);
                    chk1("prio_rd_2_en", rf_rd_2_en, 1'b0);
                    chk32("prio_rd_reg_1", 32'(rf_read_reg_1), 32'd7);
                    push_dbg();
                end
            end
            tick();
            dbg_rd_req = 1'b0;
            settle();
            chk1("resume_cpu_gnt", cpu_rd_gnt, 1'b1);
            push_cpu();
        end

        tick();
        idle_inputs();
        settle();

        // Write-port contention: CPU first, debug next cycle
        tick();
        cpu_wr_en = 1'b1; cpu_wr_reg = 5'd3; cpu_wr_data = 32'h3333_3333;
        dbg_wr_req = 1'b1; dbg_addr = 5'd4; dbg_wr_data = 32'h4444_4444;
        model_write(cpu_wr_reg, cpu_wr_data);
        settle();
        chk32("cont_cpu_reg", 32'(rf_write_reg), 32'd3);
        chk32("cont_cpu_data", rf_write_data, 32'h3333_3333);
        chk1("cont_no_ack", dbg_wr_ack, 1'b0);

        tick();
        cpu_wr_en = 1'b0;
        model_write(dbg_addr, dbg_wr_data);
        settle();
        chk1("cont_dbg_en", rf_write_en, 1'b1);
        chk32("cont_dbg_reg", 32'(rf_write_reg), 32'd4);
        chk32("cont_dbg_data", rf_write_data, 32'h4444_4444);
        chk1("cont_dbg_ack", dbg_wr_ack, 1'b1);

        tick();
        dbg_addr = 5'd0; dbg_wr_data = 32'hFFFF_0000;
        settle();
        chk1("dbg_x0_ack", dbg_wr_ack, 1'b1);
        chk1("dbg_x0_no_write", rf_write_en, 1'b0);

        // Debug read waits behind its own pending write
        tick();
        dbg_addr = 5'd9; dbg_wr_data = 32'h9999_9999; dbg_rd_req = 1'b1;
        model_write(dbg_addr, dbg_wr_data);
        settle();
        chk1("wr_first_ack", dbg_wr_ack, 1'b1);
        chk1("wr_first_rd_held", dbg_rd_gnt, 1'b0);

        tick();
        dbg_wr_req = 1'b0;
        settle();
        chk1("rd_after_wr_gnt", dbg_rd_gnt, 1'b1);
        push_dbg();

        tick();
        dbg_rd_req = 1'b0; cpu_rd_req = 1'b1; cpu_rs1 = 5'd3; cpu_rs2 = 5'd4;
        settle();
        chk1("rd34_gnt", cpu_rd_gnt, 1'b1);
        push_cpu();

        tick();
        idle_inputs();
        cpu_wr_en = 1'b1; cpu_wr_reg = 5'd31; cpu_wr_data = 32'h3131_3131;
        model_write(cpu_wr_reg, cpu_wr_data);
        settle();

        // Grant, then reset: the in-flight response must not appear
        tick();
        cpu_wr_en = 1'b0; cpu_rd_req = 1'b1; cpu_rs1 = 5'd5; cpu_rs2 = 5'd31;
        settle();
        chk1("inflight_gnt", cpu_rd_gnt, 1'b1);

        do_reset(1);
        sweep(9);
        do_reset(1);
        sweep(31);
        tick();
        settle();
        chk1("final_busy", busy, 1'b0);
        chk1("final_cpu_gnt", cpu_rd_gnt, 1'b1);
        push_cpu();

        tick();
        idle_inputs();
        settle();
        chk32("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Access controller in front of the 32x32 dual-read BRAM register file; register_file itself is unchanged.
- Three jobs:
  - Zeroes x1..x31 after every reset, because register_file has no reset.
  - Shares the read and write ports between the CPU pipeline and a debug port, with starvation protection for debug.
  - Forwards same-cycle write data, because the BRAM returns stale data when one register is written and read in the same cycle.

Parameters:
- DBG_MAX_WAIT, 8: cycles a pending debug read may be refused before it takes priority over the CPU (range 1..255).
- NUM_REGS, 32: register count; the clear sweep covers 1..NUM_REGS-1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- busy  out  1  high while reset is asserted and during the clear sweep
- cpu_rd_req  in  1  CPU read request, level
- cpu_rs1, cpu_rs2  in  5  CPU source register addresses
- cpu_rd_gnt  out  1  CPU read accepted this cycle (combinational)
- cpu_rd_valid  out  1  CPU read data valid (the cycle after the grant)
- cpu_rd_data_1, cpu_rd_data_2  out  32  CPU read data
- cpu_wr_en  in  1  CPU write, always accepted outside busy
- cpu_wr_reg  in  5  CPU write address
- cpu_wr_data  in  32  CPU write data
- dbg_rd_req, dbg_wr_req  in  1  debug requests, held until granted / acked
- dbg_addr  in  5  debug register address
- dbg_wr_data  in  32  debug write data
- dbg_rd_gnt, dbg_wr_ack  out  1  debug read accepted / debug write accepted (combinational)
- dbg_rd_valid  out  1  debug read data valid
- dbg_rd_data  out  32  debug read data
- rf_rd_1_en, rf_rd_2_en  out  1  register file read enables
- rf_read_reg_1, rf_read_reg_2  out  5  register file read addresses
- rf_write_en  out  1  register file write enable
- rf_write_reg  out  5  register file write address
- rf_write_data  out  32  register file write data
- rf_data_out_1, rf_data_out_2  in  32  register file registered outputs

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high, named reset.
- State on reset: state=CLEAR, clr_cnt=1, dbg_wait=0, all *_valid and forward flags = 0.
  - While reset is high: every grant, ack and rf enable output is 0; busy=1.
- CLEAR state:
  - Each cycle drives rf_write_en=1, rf_write_reg=clr_cnt, rf_write_data=0, then clr_cnt+1.
  - After writing NUM_REGS-1, moves to RUN. The sweep is exactly 31 cycles after reset falls.
  - busy=1 throughout. No grants or acks; requests stay pending.
- RUN write path:
  - cpu_wr_en=1: the CPU write goes to rf_write_*. dbg_wr_ack=0 that cycle.
  - Otherwise dbg_wr_req=1: the debug write goes to rf_write_* and dbg_wr_ack=1.
  - Any write to x0 drives rf_write_en=0. A debug write to x0 is still acked.
- RUN read path (one read grant per cycle):
  - Debug wins if dbg_rd_req and (!cpu_rd_req or dbg_wait==DBG_MAX_WAIT).
  - Debug read with dbg_wr_req also pending: the write is served first; the read waits (its dbg_wait keeps counting).
  - CPU grant: rf_rd_1_en=rf_rd_2_en=1, addresses cpu_rs1/cpu_rs2.
  - Debug grant: rf_rd_1_en=1, rf_read_reg_1=dbg_addr, rf_rd_2_en=0.
  - dbg_wait increments each cycle dbg_rd_req is pending and not granted, saturating at DBG_MAX_WAIT. It clears on dbg_rd_gnt.
- Latency: the grant in cycle N gives valid for exactly one cycle in N+1. The data mux is combinational on rf_data_out_*.
- Forwarding:
  - At grant, for each port, register fwd_k = rf_write_en && rf_write_reg==read_addr_k && read_addr_k!=0, and capture rf_write_data.
  - Response data = fwd_k ? captured data : rf_data_out_k.
  - This also covers a read issued on the last CLEAR cycle; it is not granted, so no special case is needed.
- Back-to-back grants every cycle are legal; response data is not held after the valid cycle.
- Reset mid-operation: an in-flight valid is suppressed. A sweep in progress restarts from clr_cnt=1.

Decomposition:
- Shared package regfile_pkg: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS, state encoding (CLEAR, RUN).
- One sub-module, regfile_fwd: per-port forward capture plus the response mux, instantiated twice.
- Arbitration, wait counter and clear FSM stay in regfile_ctrl.

Test Plan:
- Clear sweep: reset high 2 cycles, then low → rf_write_en=1 for 31 consecutive cycles, rf_write_reg 1..31, data 0; busy falls in the cycle after reg 31 is written; a cpu_rd_req held during the sweep is first granted in that cycle.
- Basic read: after the sweep, cpu_wr x5=0xDEADBEEF, next cycle read rs1=5, rs2=0 → cpu_rd_valid one cycle after the grant, data_1=0xDEADBEEF, data_2=0.
- Forwarding: cpu_wr x7=0x12345678 in the same cycle as a read of rs1=7, rs2=7 → both data outputs = 0x12345678, not stale 0; the same case with x0 → 0.
- Debug starvation: cpu_rd_req held high continuously, dbg_rd_req raised → the CPU is granted 8 cycles, then dbg_rd_gnt=1 and cpu_rd_gnt=0 for one cycle; dbg_rd_valid follows next cycle and dbg_wait returns to 0.
- Write contention: cpu_wr_en and dbg_wr_req in the same cycle, x3 and x4 → only x3 is written, dbg_wr_ack=0; next cycle x4 is written and dbg_wr_ack=1; a debug write to x0 is acked with rf_write_en=0.
- Mid-sweep reset: reset at sweep cycle 10 → busy stays 1, the sweep restarts at reg 1 and runs the full 31 cycles; a valid pending when reset hits is not emitted.
